// File: rtl/alu_mdu_if.sv
// alu_mdu_if: operand/result bundle between the EX-stage controller and alu_mdu.
// Latency: none, wires only.
// Backpressure: busy is the only flow control; the controller holds off while it is high.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             Zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B,
    input  C, Zero, busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B,
    output C, Zero, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: combinational ALU plus iterative multiply/divide engine writing HI/LO.
// Latency: ALU ops 0 cycles; MULT/DIV results WIDTH+1 edges after accept; divide by zero 1 edge.
// Backpressure: busy is high while the engine runs; starts seen during busy are dropped, not queued.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  alu_mdu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int W2  = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [W2-1:0]    ONE2 = W2'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_nx;

  // ALU result, and shift amount taken from the low bits of A
  logic [WIDTH-1:0] c;
  logic [SHW-1:0]   shamt;

  // engine registers: r_hi/r_lo hold the running product or remainder/quotient,
  // m holds the multiplicand (MULT) or divisor (DIV)
  logic [WIDTH-1:0] r_hi, r_lo, m;
  logic [SHW-1:0]   cnt;
  logic             is_div, neg_q, neg_r, dz;

  // accept-time decode
  logic             mdu_op, accept, div_op, sgn_op, sa, sb, dz_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  // per-iteration and sign-fix datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [W2-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             last_iter;

  assign shamt = bus.A[SHW-1:0];

  // combinational ALU; engine ops pass A through
  always_comb begin
    c = bus.A;
    case (bus.op)
      4'd0:    c = bus.A;
      4'd1:    c = bus.A + bus.B;
      4'd2:    c = bus.A - bus.B;
      4'd3:    c = bus.A & bus.B;
      4'd4:    c = bus.A | bus.B;
      4'd5:    c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      4'd6:    c = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'd7:    c = bus.B << shamt;
      4'd8:    c = ~(bus.A | bus.B);
      4'd9:    c = bus.A ^ bus.B;
      4'd10:   c = bus.B >> shamt;
      4'd11:   c = $signed(bus.B) >>> shamt;
      default: c = bus.A;
    endcase
  end

  assign bus.C    = c;
  assign bus.Zero = (c == '0);

  // ops 12..15 are engine ops; even encodings are the signed variants
  assign mdu_op = bus.op[3] & bus.op[2];
  assign accept = (state == IDLE) && bus.start && mdu_op;
  assign div_op = bus.op[1];
  assign sgn_op = ~bus.op[0];
  assign sa     = sgn_op & bus.A[WIDTH-1];
  assign sb     = sgn_op & bus.B[WIDTH-1];
  assign mag_a  = sa ? (~bus.A + ONE) : bus.A;
  assign mag_b  = sb ? (~bus.B + ONE) : bus.B;
  assign dz_in  = div_op && (bus.B == '0);

  // shift-add step: add multiplicand when the multiplier LSB is set, then shift right
  assign mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, m} : '0);

  // restoring step: shift in next dividend bit, subtract divisor if it fits;
  // a kept difference is always below the divisor, so the low WIDTH bits suffice
  assign div_sh   = {r_hi, r_lo[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, m});
  assign div_diff = div_sh[WIDTH-1:0] - m;

  // sign correction; MIN/-1 falls out naturally since -MIN wraps to MIN
  assign prod     = {r_hi, r_lo};
  assign prod_fix = neg_q ? (~prod + ONE2) : prod;
  assign quo_fix  = neg_q ? (~r_lo + ONE) : r_lo;
  assign rem_fix  = neg_r ? (~r_hi + ONE) : r_hi;

  assign last_iter = (cnt == SHW'(WIDTH - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and busy
  always_comb begin
    state_nx = state;
    bus.busy = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_nx = dz_in ? FIX : RUN;
      RUN:     if (last_iter) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // engine datapath: latch operands on accept, iterate in RUN, publish in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      m        <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div <= div_op;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= dz_in;
            cnt    <= '0;
            if (div_op) begin
              // divide by zero parks raw A in r_hi so FIX can return it as-is
              r_hi <= dz_in ? bus.A : '0;
              r_lo <= mag_a;
              m    <= mag_b;
            end else begin
              r_hi <= '0;
              r_lo <= mag_b;
              m    <= mag_a;
            end
          end
        end
        RUN: begin
          cnt <= cnt + SHW'(1);
          if (is_div) begin
            r_hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], div_ge};
          end else begin
            r_hi <= mul_sum[WIDTH:1];
            r_lo <= {mul_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          bus.done <= 1'b1;
          if (dz) begin
            bus.hi <= r_hi;
            bus.lo <= '1;
          end else if (is_div) begin
            bus.hi <= rem_fix;
            bus.lo <= quo_fix;
          end else begin
            bus.hi <= prod_fix[W2-1:WIDTH];
            bus.lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed checks of alu_mdu at WIDTH=32 and WIDTH=8.
// Latency: checks ALU at zero latency and engine completion edges.
// Backpressure: exercises busy, ignored starts, reset abort and back-to-back issue.
module tb_alu_mdu;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(32)) b32 ();
  alu_mdu_if #(.WIDTH(8))  b8  ();

  alu_mdu #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
  alu_mdu #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));

  // issue one engine op on the 32-bit unit; returns edges from accept to done
  // (-1 on timeout) and whether busy stayed high until done
  task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    b32.start = 1'b1;
    b32.op    = op;
    b32.A     = a;
    b32.B     = b;
    @(posedge clk); #1;
    b32.start = 1'b0;
    busy_ok = (b32.busy === 1'b1);
    lat     = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (b32.done === 1'b1) begin
        lat = n;
        if (b32.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (b32.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b32.start = 1'b0; b32.op = 4'd0; b32.A = '0; b32.B = '0;
    b8.start  = 1'b0; b8.op  = 4'd0; b8.A  = '0; b8.B  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (b32.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", b32.busy); end
    n_chk++; if (b32.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", b32.done); end
    n_chk++; if (b32.hi !== 32'h0) begin n_fail++; $display("FAIL rst_hi: got %h want 0", b32.hi); end
    n_chk++; if (b32.lo !== 32'h0) begin n_fail++; $display("FAIL rst_lo: got %h want 0", b32.lo); end
    n_chk++; if (b8.busy !== 1'b0) begin n_fail++; $display("FAIL rst8_busy: got %b want 0", b8.busy); end
    n_chk++; if (b8.lo !== 8'h0) begin n_fail++; $display("FAIL rst8_lo: got %h want 0", b8.lo); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_comb();
    logic [3:0]  vop [15];
    logic [31:0] va  [15];
    logic [31:0] vb  [15];
    logic [31:0] vc  [15];
    vop[0]  = 4'd1;  va[0]  = 32'd5;        vb[0]  = 32'hFFFFFFFD; vc[0]  = 32'd2;
    vop[1]  = 4'd2;  va[1]  = 32'd7;        vb[1]  = 32'd7;        vc[1]  = 32'd0;
    vop[2]  = 4'd5;  va[2]  = 32'hFFFFFFFF; vb[2]  = 32'd1;        vc[2]  = 32'd1;
    vop[3]  = 4'd6;  va[3]  = 32'hFFFFFFFF; vb[3]  = 32'd1;        vc[3]  = 32'd0;
    vop[4]  = 4'd11; va[4]  = 32'd4;        vb[4]  = 32'h80000000; vc[4]  = 32'hF8000000;
    vop[5]  = 4'd9;  va[5]  = 32'h0000F0F0; vb[5]  = 32'h00000FF0; vc[5]  = 32'h0000FF00;
    vop[6]  = 4'd10; va[6]  = 32'd4;        vb[6]  = 32'h80000000; vc[6]  = 32'h08000000;
    vop[7]  = 4'd7;  va[7]  = 32'd33;       vb[7]  = 32'd1;        vc[7]  = 32'd2;
    vop[8]  = 4'd8;  va[8]  = 32'd0;        vb[8]  = 32'd0;        vc[8]  = 32'hFFFFFFFF;
    vop[9]  = 4'd3;  va[9]  = 32'h0000F0F0; vb[9]  = 32'h00000FF0; vc[9]  = 32'h000000F0;
    vop[10] = 4'd4;  va[10] = 32'h0000F0F0; vb[10] = 32'h00000FF0; vc[10] = 32'h0000FFF0;
    vop[11] = 4'd0;  va[11] = 32'h00001234; vb[11] = 32'h0000FFFF; vc[11] = 32'h00001234;
    vop[12] = 4'd13; va[12] = 32'h0000ABCD; vb[12] = 32'd1;        vc[12] = 32'h0000ABCD;
    vop[13] = 4'd5;  va[13] = 32'd1;        vb[13] = 32'hFFFFFFFF; vc[13] = 32'd0;
    vop[14] = 4'd2;  va[14] = 32'd0;        vb[14] = 32'd1;        vc[14] = 32'hFFFFFFFF;
    for (int i = 0; i < 15; i++) begin
      b32.op = vop[i]; b32.A = va[i]; b32.B = vb[i];
      #1;
      n_chk++;
      if (b32.C !== vc[i]) begin
        n_fail++; $display("FAIL comb_c[%0d]: got %h want %h", i, b32.C, vc[i]);
      end
      n_chk++;
      if (b32.Zero !== (vc[i] == 32'h0)) begin
        n_fail++; $display("FAIL comb_zero[%0d]: got %b want %b", i, b32.Zero, (vc[i] == 32'h0));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int lat; bit bok;
    run32(4'd12, 32'hFFFFFFFD, 32'd7, lat, bok);
    n_chk++; if (lat != 33) begin n_fail++; $display("FAIL mult_lat: got %0d want 33", lat); end
    n_chk++; if (bok !== 1'b1) begin n_fail++; $display("FAIL mult_busy: got %b want 1", bok); end
    n_chk++; if (b32.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", b32.hi); end
    n_chk++; if (b32.lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", b32.lo); end
    @(posedge clk); #1;
    n_chk++; if (b32.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", b32.done); end
    n_chk++; if (b32.lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL lo_hold: got %h want ffffffeb", b32.lo); end
    run32(4'd13, 32'hFFFFFFFF, 32'd2, lat, bok);
    n_chk++; if (b32.hi !== 32'h1) begin n_fail++; $display("FAIL multu_hi: got %h want 1", b32.hi); end
    n_chk++; if (b32.lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffe", b32.lo); end
  endtask

  task automatic test_div();
    int lat; bit bok;
    run32(4'd14, 32'hFFFFFFF9, 32'd2, lat, bok);
    n_chk++; if (lat != 33) begin n_fail++; $display("FAIL div_lat: got %0d want 33", lat); end
    n_chk++; if (b32.lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", b32.lo); end
    n_chk++; if (b32.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", b32.hi); end
    run32(4'd15, 32'd100, 32'd7, lat, bok);
    n_chk++; if (b32.lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want e", b32.lo); end
    n_chk++; if (b32.hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 2", b32.hi); end
    run32(4'd14, 32'h80000000, 32'hFFFFFFFF, lat, bok);
    n_chk++; if (b32.lo !== 32'h80000000) begin n_fail++; $display("FAIL divmin_lo: got %h want 80000000", b32.lo); end
    n_chk++; if (b32.hi !== 32'h0) begin n_fail++; $display("FAIL divmin_hi: got %h want 0", b32.hi); end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    run32(4'd15, 32'd5, 32'd0, lat, bok);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL dz_lat: got %0d want 1", lat); end
    n_chk++; if (b32.hi !== 32'd5) begin n_fail++; $display("FAIL dz_hi: got %h want 5", b32.hi); end
    n_chk++; if (b32.lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_lo: got %h want ffffffff", b32.lo); end
    // issued in the done cycle of the previous op
    run32(4'd13, 32'd3, 32'd4, lat, bok);
    n_chk++; if (lat != 33) begin n_fail++; $display("FAIL b2b_lat: got %0d want 33", lat); end
    n_chk++; if (bok !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", bok); end
    n_chk++; if (b32.lo !== 32'd12) begin n_fail++; $display("FAIL b2b_lo: got %h want c", b32.lo); end
    n_chk++; if (b32.hi !== 32'd0) begin n_fail++; $display("FAIL b2b_hi: got %h want 0", b32.hi); end
  endtask

  task automatic test_robust();
    int lat;
    bit seen;
    b32.start = 1'b1; b32.op = 4'd13; b32.A = 32'd6; b32.B = 32'd7;
    @(posedge clk); #1;
    // keep requesting a divide with new operands while busy
    b32.op = 4'd14; b32.A = 32'd100; b32.B = 32'd0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin b32.start = 1'b0; b32.A = 32'h55; b32.B = 32'h3; end
      if (b32.done === 1'b1) begin lat = n; break; end
    end
    n_chk++; if (lat != 33) begin n_fail++; $display("FAIL ign_lat: got %0d want 33", lat); end
    n_chk++; if (b32.lo !== 32'd42) begin n_fail++; $display("FAIL ign_lo: got %h want 2a", b32.lo); end
    n_chk++; if (b32.hi !== 32'd0) begin n_fail++; $display("FAIL ign_hi: got %h want 0", b32.hi); end
    @(posedge clk); #1;
    // reset partway through a multiply
    b32.start = 1'b1; b32.op = 4'd12; b32.A = 32'd6; b32.B = 32'd7;
    @(posedge clk); #1;
    b32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (b32.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", b32.busy); end
    n_chk++; if (b32.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", b32.done); end
    n_chk++; if (b32.lo !== 32'd0) begin n_fail++; $display("FAIL abort_lo: got %h want 0", b32.lo); end
    n_chk++; if (b32.hi !== 32'd0) begin n_fail++; $display("FAIL abort_hi: got %h want 0", b32.hi); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b32.done !== 1'b0) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_nodone: got %b want 0", seen); end
  endtask

  task automatic test_width8();
    int lat;
    b8.start = 1'b1; b8.op = 4'd13; b8.A = 8'hFF; b8.B = 8'hFF;
    @(posedge clk); #1;
    b8.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (b8.done === 1'b1) begin lat = n; break; end
    end
    n_chk++; if (lat != 9) begin n_fail++; $display("FAIL w8_lat: got %0d want 9", lat); end
    n_chk++; if (b8.hi !== 8'hFE) begin n_fail++; $display("FAIL w8_hi: got %h want fe", b8.hi); end
    n_chk++; if (b8.lo !== 8'h01) begin n_fail++; $display("FAIL w8_lo: got %h want 01", b8.lo); end
    b8.op = 4'd7; b8.A = 8'd9; b8.B = 8'd1;
    #1;
    n_chk++; if (b8.C !== 8'd2) begin n_fail++; $display("FAIL w8_sll: got %h want 02", b8.C); end
    b8.op = 4'd11; b8.A = 8'd3; b8.B = 8'h80;
    #1;
    n_chk++; if (b8.C !== 8'hF0) begin n_fail++; $display("FAIL w8_sra: got %h want f0", b8.C); end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_mult();
    test_div();
    test_back_to_back();
    test_robust();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised integer execute unit for the next CPU generation. Combinational ALU ops (NOP/ADD/SUB/AND/OR/SLT/SLTU/SLL/NOR plus XOR/SRL/SRA) sit alongside an iterative multiply/divide engine. The engine writes dedicated HI/LO registers through a start/busy/done handshake. It sits in the EX stage; the controller stalls on busy.

Parameters:
WIDTH, 32, datapath width in bits (power of two, >= 8)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request a MULT/MULTU/DIV/DIVU; sampled only in IDLE with op >= 12
op  in  4  operation select (encoding below)
A  in  WIDTH  operand A (shift amount in A[SHW-1:0] for shifts)
B  in  WIDTH  operand B (shifted value for shifts)
C  out  WIDTH  combinational result
Zero  out  1  C == 0
busy  out  1  engine running; new starts ignored
done  out  1  one-cycle pulse: hi/lo just updated
hi  out  WIDTH  product upper half / remainder
lo  out  WIDTH  product lower half / quotient

Behaviour:
- op encoding: 0 NOP C=A; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 SLT signed; 6 SLTU; 7 SLL C=B<<A[SHW-1:0]; 8 NOR; 9 XOR; 10 SRL; 11 SRA (arithmetic on B); 12 MULT signed; 13 MULTU; 14 DIV signed; 15 DIVU.
- Ops 0-11 are purely combinational, zero latency, independent of engine state. For ops 12-15, C = A. ADD/SUB wrap modulo 2^WIDTH with no overflow flag. SLT/SLTU give 1 or 0.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset mid-operation aborts the operation and clears hi/lo at that edge; no done pulse follows.
- FSM states: IDLE, RUN, FIX.
- IDLE -> RUN on the edge where start=1 and op in 12-15 (the accept edge E0). A, B, op and operand signs are latched at E0. start with op < 12 is ignored.
- RUN: WIDTH iterations, one per cycle. MULT uses shift-add on magnitudes. DIV uses restoring division on magnitudes.
- RUN -> FIX after the WIDTH-th iteration. FIX applies sign correction, then returns to IDLE.
- hi/lo update, done=1 and busy=0 all take effect on edge E0+WIDTH+1. busy=1 from edge E0 until that edge.
- Divide by zero (B==0 at accept): skips RUN. On edge E0+1: hi=A, lo=all ones, done=1. Applies to both DIV and DIVU.
- Signed rules: product is the full 2*WIDTH two's-complement result. Quotient sign = sign(A) xor sign(B), truncating toward zero. Remainder takes the sign of A. DIV MIN/-1 gives lo=MIN, hi=0.
- done is high exactly one cycle. A start in the done cycle is accepted (back-to-back, no bubble).
- start while busy is ignored and not queued. Changing A/B/op while busy has no effect on the result.
- hi/lo hold their value until the next completion or reset.

Test Plan:
1. WIDTH=32 combinational ops:
   - ADD 5,-3 -> C=2, Zero=0.
   - SUB 7,7 -> C=0, Zero=1.
   - SLT -1,1 -> 1; SLTU -1,1 -> 0.
   - SRA A=4, B=0x80000000 -> 0xF8000000.
   - XOR 0xF0F0,0x0FF0 -> 0xFF00.
2. MULT A=-3, B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly 33 edges after accept, busy high throughout. MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
3. Division results:
   - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 100/7 -> lo=14, hi=2.
   - DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
4. DIVU A=5, B=0 -> done one edge after accept, hi=5, lo=0xFFFFFFFF. Immediately issue MULTU 3*4 in the done cycle -> accepted, lo=12 after 33 edges.
5. Robustness during MULT 6*7:
   - Pulse start with DIV and change A/B while busy -> ignored; result still lo=42.
   - Separate run: assert rst at iteration 10 -> next edge busy=0, done=0, hi=lo=0; no done afterwards.
6. WIDTH=8 instance: MULTU 255*255 -> hi=0xFE, lo=0x01, latency 9. SLL A=9, B=1 uses A[2:0]=1 -> C=2.
